// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared FSM state type and sizing constants for the shift-add multiplier
package shift_add_multiplier_pkg;

  localparam int OP_W       = 4;
  localparam int PROD_W     = 8;
  localparam int ITERATIONS = 4;

  // Terminal count of the 2-bit iteration counter
  localparam logic [1:0] LAST_ITER = 2'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_cla.sv
// rtl/shift_add_multiplier_cla.sv - 4-bit carry-lookahead adder used for the accumulate step
module CLA_adder
  import shift_add_multiplier_pkg::*;
(
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  input  logic            CarryIn0,
  output logic [OP_W-1:0] Sum,
  output logic            carry_out
);

  logic [OP_W-1:0] w_g;
  logic [OP_W-1:0] w_p;
  logic [OP_W:0]   w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Every carry is a flat sum-of-products of generate/propagate terms, no ripple
  assign w_c[0] = CarryIn0;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign Sum       = w_p ^ w_c[OP_W-1:0];
  assign carry_out = w_c[OP_W];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential 4x4 unsigned shift-add multiplier, one iteration per clock
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t              r_state;
  logic [OP_W-1:0]     r_m;
  logic [OP_W-1:0]     r_q;
  logic [OP_W-1:0]     r_acc;
  logic [1:0]          r_count;
  logic [PROD_W-1:0]   r_product;
  logic                r_done;

  logic [OP_W-1:0]     w_sum;
  logic                w_carry;
  logic                w_c_next;
  logic [OP_W-1:0]     w_acc_pre;
  logic [OP_W-1:0]     w_acc_shift;
  logic [OP_W-1:0]     w_q_shift;

  CLA_adder u_cla (
    .A         (r_acc),
    .B         (r_m),
    .CarryIn0  (1'b0),
    .Sum       (w_sum),
    .carry_out (w_carry)
  );

  // Add-or-hold, then shift {C,ACC,Q} right; C re-enters as the new ACC MSB
  assign w_c_next    = r_q[0] ? w_carry : 1'b0;
  assign w_acc_pre   = r_q[0] ? w_sum   : r_acc;
  assign w_acc_shift = {w_c_next, w_acc_pre[OP_W-1:1]};
  assign w_q_shift   = {w_acc_pre[0], r_q[OP_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_acc   <= '0;
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_shift;
          r_q     <= w_q_shift;
          r_count <= r_count + 2'd1;
          if (r_count == LAST_ITER) begin
            r_product <= {w_acc_shift, w_q_shift};
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state == RUN) || (r_state == DONE);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks;
  int failures;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: scramble a/b every RUN cycle, 2: pulse start with 15x15 during RUN
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input int mode,
                        input int ncyc, output logic [7:0] prod, output int lat,
                        output int nbusy, output int ndone, output int nchg);
    logic [7:0] prev;
    @(negedge clk);
    prev  = product;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; nbusy = 0; ndone = 0; nchg = 0; prod = 8'hxx;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat  = i;
          prod = product;
        end
      end else if (i <= 4 && product !== prev) begin
        nchg++;
      end
      if (mode == 1) begin
        a = 4'($urandom_range(15));
        b = 4'($urandom_range(15));
      end
      if (mode == 2) begin
        start = (i == 2);
        a     = 4'hF;
        b     = 4'hF;
      end
    end
    start = 1'b0;
  endtask

  logic [7:0] p;
  int lat, nb, nd, nc;
  int late_done;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd15, 4'd15, 0, 7, p, lat, nb, nd, nc);
    check("15x15_product", p, 8'hE1);
    check("15x15_latency", lat, 5);
    check("15x15_busy_cycles", nb, 5);
    check("15x15_done_pulses", nd, 1);
    check("15x15_product_stable_in_run", nc, 0);

    run_op(4'd9, 4'd6, 0, 6, p, lat, nb, nd, nc);
    check("9x6_product", p, 8'h36);
    check("9x6_product_stable_in_run", nc, 0);
    repeat (3) @(negedge clk);
    check("product_held_idle", product, 8'h36);

    run_op(4'd0, 4'd13, 0, 6, p, lat, nb, nd, nc);
    check("0x13_product", p, 8'h00);
    run_op(4'd7, 4'd0, 0, 6, p, lat, nb, nd, nc);
    check("7x0_product", p, 8'h00);

    run_op(4'd3, 4'd5, 2, 9, p, lat, nb, nd, nc);
    check("3x5_ignored_start_product", p, 8'h0F);
    check("3x5_ignored_start_done_pulses", nd, 1);
    check("3x5_ignored_start_final_product", product, 8'h0F);
    check("3x5_ignored_start_idle", busy, 0);

    run_op(4'd13, 4'd14, 1, 6, p, lat, nb, nd, nc);
    check("13x14_scrambled_product", p, 8'hB6);
    check("13x14_scrambled_latency", lat, 5);

    // Abort 12x11 with reset at the second RUN edge
    @(negedge clk);
    a = 4'd12; b = 4'd11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 8'h00);
    late_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) late_done++;
    end
    check("abort_no_done", late_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'd2, 4'd3, 0, 6, p, lat, nb, nd, nc);
    check("2x3_after_abort_product", p, 8'h06);
    check("2x3_after_abort_latency", lat, 5);

    // Back-to-back sweep: next start lands in the cycle right after done
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 0, 5, p, lat, nb, nd, nc);
        check($sformatf("sweep_%0dx%0d_product", i, j), p, 32'(i * j));
        check($sformatf("sweep_%0dx%0d_latency", i, j), lat, 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001: Parameters SHALL be none; operand width is fixed at 4 bits to match the 4-bit carry-lookahead adder.
REQ-002: clk  input  1  single rising-edge clock for all state.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005: a  input  4  unsigned multiplicand; captured on start acceptance.
REQ-006: b  input  4  unsigned multiplier; captured on start acceptance.
REQ-007: busy  output  1  high while in RUN or DONE.
REQ-008: done  output  1  one-cycle pulse; product valid.
REQ-009: product  output  8  unsigned a*b result; registered.

Function
REQ-010: FSM states SHALL be IDLE, RUN and DONE.
REQ-011: IDLE->RUN on a rising edge where start=1; on that edge M<=a, Q<=b, ACC<=0, C<=0, count<=0.
REQ-012: Each RUN edge SHALL perform one iteration: if Q[0]=1, {C,ACC}<=ACC+M via the adder with carry-in 0; else C<=0 and ACC is unchanged.
REQ-013: The same RUN edge SHALL then shift {C,ACC,Q} right by one, discarding Q[0], and increment count.
REQ-014: RUN SHALL last exactly 4 edges; on the 4th edge (count=3) the state goes to DONE, product<={ACC,Q} post-shift and done<=1.
REQ-015: Latency: start accepted on edge k -> done high in the cycle between edges k+4 and k+5.
REQ-016: DONE->IDLE unconditionally on the next edge; done<=0.
REQ-017: start in RUN or DONE SHALL be ignored, with no queuing and no effect on the in-flight result.
REQ-018: Changes to a/b after acceptance SHALL NOT affect the result.
REQ-019: product SHALL hold its last value until the next DONE entry, and SHALL not change during RUN.
REQ-020: Edge cases: a=0 or b=0 -> 0; 15*15 -> 225 with no overflow, because the 8-bit width is always sufficient.
REQ-021: done SHALL be a registered output, and busy SHALL be decoded from the state register only.

Reset
REQ-022: rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, product=0x00, ACC=0, Q=0, M=0, C=0, count=0.
REQ-023: Reset mid-operation SHALL abort the multiply with no done pulse; the first start after release SHALL behave as from power-up.
REQ-024: start high during reset or on the release edge SHALL NOT be required to be accepted; acceptance is guaranteed from the first edge after rst_n is sampled high.

Structure
REQ-025: A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the constants OP_W=4, PROD_W=8, ITERATIONS=4.
REQ-026: The single sub-module SHALL be one instance of the 4-bit carry-lookahead adder CLA_adder: A=ACC, B=M, CarryIn0=0, Sum->next ACC, carry_out->next C.
REQ-027: The iteration counter SHALL be 2 bits, with terminal value ITERATIONS-1.

Verification
REQ-028: Reset then start with a=15, b=15 -> busy high for 5 cycles; done pulses exactly once at edge k+4; product=0xE1 (225).
REQ-029: a=9, b=6 -> product=0x36 (54); a=0, b=13 -> 0x00; a=7, b=0 -> 0x00; product unchanged between operations.
REQ-030: a=3, b=5 accepted, then start pulsed with a=15, b=15 during RUN -> product=0x0F (15); only one done pulse.
REQ-031: a=12, b=11 accepted, rst_n low at the 2nd RUN edge -> all outputs 0 immediately, no done; then a=2, b=3 -> product=0x06.
REQ-032: Exhaustive sweep of all 256 (a,b) pairs back-to-back, start re-asserted in the cycle after done -> every product equals a*b, and each done lands 5 cycles after its accepting edge.
REQ-033: a and b toggled randomly every cycle during RUN -> result equals the product of the values captured at acceptance.
